// File: rtl/cnn_maxpool_stream.sv
// 2x2 stride-2 streaming pooling over a raster-order multi-channel frame (max; average when POOL_AVG_EN is defined).
// Latency: result registered 1 cycle after the odd-row/odd-column beat. No backpressure: accepts one pixel per cycle.
module cnn_maxpool_stream #(
    parameter int CI    = 3,
    parameter int IF_BW = 8,
    parameter int IN_W  = 8,
    parameter int IN_H  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [CI*IF_BW-1:0]   i_data,
    output logic                  o_valid,
    output logic [CI*IF_BW-1:0]   o_data,
    output logic                  o_frame_done
);

    localparam int XW   = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int YW   = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int LB_N = IN_W / 2;
    localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;
`ifdef POOL_AVG_EN
    localparam int PW = IF_BW + 1;
`else
    localparam int PW = IF_BW;
`endif

    logic [XW-1:0]         x_q, x_eff, x_nxt;
    logic [YW-1:0]         y_q, y_eff, y_nxt;
    logic                  x_last, y_last, frame_last;
    logic [LBW-1:0]        lb_idx;
    logic [CI*IF_BW-1:0]   h_reg;
    logic [CI*PW-1:0]      pair;
    logic [CI*PW-1:0]      lb_rd;
    logic [CI*IF_BW-1:0]   fin;
    logic [CI*PW-1:0]      lb [LB_N];
`ifdef POOL_AVG_EN
    logic [IF_BW+1:0]      sum4;
`endif

    // A start-of-frame beat is taken as (0,0) whatever the counters say.
    assign x_eff      = i_sof ? '0 : x_q;
    assign y_eff      = i_sof ? '0 : y_q;
    assign x_last     = (x_eff == XW'(IN_W - 1));
    assign y_last     = (y_eff == YW'(IN_H - 1));
    assign frame_last = x_last && y_last;
    assign x_nxt      = x_last ? '0 : x_eff + 1'b1;
    assign y_nxt      = x_last ? (y_last ? '0 : y_eff + 1'b1) : y_eff;
    assign lb_idx     = LBW'(x_eff >> 1);
    assign lb_rd      = lb[lb_idx];

    always_comb begin
        pair = '0;
        fin  = '0;
`ifdef POOL_AVG_EN
        sum4 = '0;
`endif
        for (int c = 0; c < CI; c++) begin
`ifdef POOL_AVG_EN
            pair[c*PW +: PW]   = {1'b0, h_reg[c*IF_BW +: IF_BW]} + {1'b0, i_data[c*IF_BW +: IF_BW]};
            sum4               = {1'b0, lb_rd[c*PW +: PW]} + {1'b0, pair[c*PW +: PW]};
            fin[c*IF_BW +: IF_BW] = sum4[IF_BW+1:2];
`else
            pair[c*PW +: PW] = (h_reg[c*IF_BW +: IF_BW] > i_data[c*IF_BW +: IF_BW]) ?
                               h_reg[c*IF_BW +: IF_BW] : i_data[c*IF_BW +: IF_BW];
            fin[c*IF_BW +: IF_BW] = (lb_rd[c*PW +: PW] > pair[c*PW +: PW]) ?
                                    lb_rd[c*PW +: PW] : pair[c*PW +: PW];
`endif
        end
    end

    // Line buffer needs no reset: every entry is rewritten on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (i_valid && x_eff[0] && !y_eff[0]) begin
            lb[lb_idx] <= pair;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q          <= '0;
            y_q          <= '0;
            h_reg        <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_valid) begin
                x_q <= x_nxt;
                y_q <= y_nxt;
                if (!x_eff[0]) begin
                    h_reg <= i_data;
                end
                if (x_eff[0] && y_eff[0]) begin
                    o_valid <= 1'b1;
                    o_data  <= fin;
                end
                if (frame_last) begin
                    o_frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_maxpool_stream.sv
// Bench for cnn_maxpool_stream: directed frame table, reset/abort sequences and random frames against an image-array model.
module tb_cnn_maxpool_stream;
    localparam int CI = 3, BW = 8, W = 8, H = 8, DW = CI*BW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_frame_done;

    cnn_maxpool_stream #(.CI(CI), .IF_BW(BW), .IN_W(W), .IN_H(H)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
        .o_valid(o_valid), .o_data(o_data), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int img [H][W][CI];
    int mx = 0, my = 0;
    logic [DW-1:0] hold = '0;
    logic [DW-1:0] cap[$];
    int done_cnt = 0, done_with_valid = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pool(input int x, input int y);
        logic [DW-1:0] r;
        int a, b, e, f, v;
        r = '0;
        for (int c = 0; c < CI; c++) begin
            a = img[y-1][x-1][c]; b = img[y-1][x][c];
            e = img[y][x-1][c];   f = img[y][x][c];
`ifdef POOL_AVG_EN
            v = (a + b + e + f) / 4;
`else
            v = a;
            if (b > v) v = b;
            if (e > v) v = e;
            if (f > v) v = f;
`endif
            r[c*BW +: BW] = v[BW-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] pixel(input int pat, input int x, input int y);
        logic [DW-1:0] d;
        int v;
        d = '0;
        for (int c = 0; c < CI; c++) begin
            case (pat)
                0: v = x + 8*y;
                1: v = (c == 0) ? x : (c == 1) ? y : 255 - (x + 8*y);
                default: v = int'($urandom_range(0, 255));
            endcase
            d[c*BW +: BW] = v[BW-1:0];
        end
        return d;
    endfunction

    // One clock: drive inputs, predict from the image model, compare after the edge.
    task automatic cycle(input bit v, input bit sof, input logic [DW-1:0] d);
        bit ev, ed;
        @(negedge clk);
        i_valid = v; i_sof = sof; i_data = d;
        ev = 1'b0; ed = 1'b0;
        if (v) begin
            if (sof) begin mx = 0; my = 0; end
            for (int c = 0; c < CI; c++) img[my][mx][c] = int'(d[c*BW +: BW]);
            if ((mx % 2 == 1) && (my % 2 == 1)) begin ev = 1'b1; hold = pool(mx, my); end
            if (mx == W-1 && my == H-1) ed = 1'b1;
            if (mx == W-1) begin mx = 0; my = (my == H-1) ? 0 : my + 1; end
            else mx = mx + 1;
        end
        @(posedge clk); #1;
        check("o_valid", 64'(o_valid), 64'(ev));
        check("o_frame_done", 64'(o_frame_done), 64'(ed));
        check(ev ? "o_data" : "o_data_hold", 64'(o_data), 64'(hold));
        if (o_valid) cap.push_back(o_data);
        if (o_frame_done) begin
            done_cnt++;
            if (o_valid) done_with_valid++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
    endtask

    task automatic send(input int pat, input int gap, input bit sof_first, input int nbeats);
        int k;
        k = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (k < nbeats) begin
                    if (k > 0 && gap > 0) idle(int'($urandom_range(0, gap)));
                    cycle(1'b1, sof_first && k == 0, pixel(pat, x, y));
                end
                k++;
            end
    endtask

    task automatic clear_obs();
        cap.delete();
        done_cnt = 0;
        done_with_valid = 0;
    endtask

    function automatic logic [DW-1:0] cap_at(input int i);
        if (i >= 0 && i < cap.size()) return cap[i];
        return 'x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_data), 64'd0);
        check("rst_o_frame_done", 64'(o_frame_done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mx = 0; my = 0; hold = '0;
    endtask

    typedef struct {
        int            pat;
        int            gap;
        logic [DW-1:0] first;
        logic [DW-1:0] last;
        int            cnt;
    } vec_t;

`ifdef POOL_AVG_EN
    localparam logic [DW-1:0] P0_FIRST = 24'h040404, P0_LAST = 24'h3A3A3A;
    localparam logic [DW-1:0] P1_FIRST = 24'hFA0000, P1_LAST = 24'hC40606;
`else
    localparam logic [DW-1:0] P0_FIRST = 24'h090909, P0_LAST = 24'h3F3F3F;
    localparam logic [DW-1:0] P1_FIRST = 24'hFF0101, P1_LAST = 24'hC90707;
`endif

    vec_t tbl[4];

    initial begin
        tbl[0] = '{pat: 0, gap: 0, first: P0_FIRST, last: P0_LAST, cnt: 16};
        tbl[1] = '{pat: 0, gap: 3, first: P0_FIRST, last: P0_LAST, cnt: 16};
        tbl[2] = '{pat: 1, gap: 0, first: P1_FIRST, last: P1_LAST, cnt: 16};
        tbl[3] = '{pat: 1, gap: 2, first: P1_FIRST, last: P1_LAST, cnt: 16};

        #2;
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_o_data", 64'(o_data), 64'd0);
        check("reset_o_frame_done", 64'(o_frame_done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);

        for (int t = 0; t < 4; t++) begin
            clear_obs();
            send(tbl[t].pat, tbl[t].gap, 1'b0, W*H);
            idle(2);
            check($sformatf("tbl%0d_count", t), 64'(cap.size()), 64'(tbl[t].cnt));
            check($sformatf("tbl%0d_first", t), 64'(cap_at(0)), 64'(tbl[t].first));
            check($sformatf("tbl%0d_last", t), 64'(cap_at(cap.size()-1)), 64'(tbl[t].last));
            check($sformatf("tbl%0d_done_cnt", t), 64'(done_cnt), 64'd1);
            check($sformatf("tbl%0d_done_with_valid", t), 64'(done_with_valid), 64'd1);
        end

        // k-th result of the ramp frame follows 9+2i+16j (max) or the averaged window
        clear_obs();
        send(0, 0, 1'b1, W*H);
        idle(1);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                int v;
`ifdef POOL_AVG_EN
                v = (4*(2*i + 16*j) + 18) / 4;
`else
                v = 9 + 2*i + 16*j;
`endif
                check($sformatf("ramp_%0d_%0d", i, j), 64'(cap_at(j*4 + i)),
                      64'({3{v[7:0]}}));
            end

        // Reset mid-frame after 20 beats, then a fresh frame without i_sof
        send(2, 1, 1'b0, 20);
        do_reset();
        clear_obs();
        send(0, 0, 1'b0, W*H);
        idle(2);
        check("rst_count", 64'(cap.size()), 64'd16);
        check("rst_first", 64'(cap_at(0)), 64'(P0_FIRST));
        check("rst_last", 64'(cap_at(15)), 64'(P0_LAST));
        check("rst_done_cnt", 64'(done_cnt), 64'd1);

        // Frame aborted by i_sof at beat 37 (8 results already out), then a full frame
        clear_obs();
        send(2, 0, 1'b0, 37);
        send(0, 0, 1'b1, W*H);
        idle(2);
        check("sof_count", 64'(cap.size()), 64'd24);
        check("sof_first", 64'(cap_at(8)), 64'(P0_FIRST));
        check("sof_last", 64'(cap_at(23)), 64'(P0_LAST));
        check("sof_done_cnt", 64'(done_cnt), 64'd1);

        // Random frames with gaps, random start-of-frame and occasional aborts
        for (int r = 0; r < 6; r++) begin
            if (r == 3) send(2, 2, 1'b1, int'($urandom_range(1, 60)));
            send(2, 3, 1'($urandom_range(0, 1)) || r == 4, W*H);
            idle(int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
